avl_bus_arbiter: RTL and testbench

//  N-master to 1-slave Avalon-MM arbiter with pipelined-read support; lets the instruction and data

---
 rtl/core_bus_pkg.sv | 25 ++
 rtl/avl_arb_id_fifo.sv | 73 +++++++
 rtl/avl_bus_arbiter.sv | 146 ++++++++++++++
 tb/tb_avl_bus_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_bus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | core_bus_pkg                                                               |
// | Shared types and width helpers for the core memory-bus arbiter.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package core_bus_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  // Master-ID width; never collapses to zero bits.
  function automatic int id_width(input int num_masters);
    return (num_masters > 1) ? $clog2(num_masters) : 1;
  endfunction

  // Outstanding-read counter width; one extra bit so "full" is representable.
  function automatic int cnt_width(input int max_pending);
    return $clog2(max_pending) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/avl_arb_id_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | avl_arb_id_fifo                                                            |
// | In-order FIFO of master IDs for reads awaiting readdatavalid.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module avl_arb_id_fifo
  import core_bus_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic                        clk,
  input  logic                        rest,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_id,
  input  logic                        pop,
  output logic [WIDTH-1:0]            head,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        full,
  output logic                        empty
);

  localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cnt_w = cnt_width(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               w_do_push;
  logic               w_do_pop;

  function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
    return (p == c_ptr_w'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (r_count == c_cnt_w'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign head      = r_mem[r_rd_ptr];
  assign w_do_pop  = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_id;
    end
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/avl_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | avl_bus_arbiter                                                            |
// | N-master to 1-slave Avalon-MM arbiter with in-order pipelined reads.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module avl_bus_arbiter
  import core_bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_PENDING = 4,
  parameter int ARB_MODE    = 0
) (
  input  logic                                  clk,
  input  logic                                  rest,
  input  logic [NUM_MASTERS-1:0][ADDR_W-1:0]    m_address,
  input  logic [NUM_MASTERS-1:0]                m_read,
  input  logic [NUM_MASTERS-1:0]                m_write,
  input  logic [NUM_MASTERS-1:0][DATA_W-1:0]    m_writedata,
  input  logic [NUM_MASTERS-1:0][DATA_W/8-1:0]  m_byteenable,
  output logic [NUM_MASTERS-1:0]                m_waitrequest,
  output logic [DATA_W-1:0]                     m_readdata,
  output logic [NUM_MASTERS-1:0]                m_readdatavalid,
  output logic [ADDR_W-1:0]                     s_address,
  output logic                                  s_read,
  output logic                                  s_write,
  output logic [DATA_W-1:0]                     s_writedata,
  output logic [DATA_W/8-1:0]                   s_byteenable,
  input  logic                                  s_waitrequest,
  input  logic [DATA_W-1:0]                     s_readdata,
  input  logic                                  s_readdatavalid,
  output logic                                  err_unexp_rdv
);

  localparam int        c_id_w  = id_width(NUM_MASTERS);
  localparam int        c_cnt_w = cnt_width(MAX_PENDING);
  localparam arb_mode_e c_mode  = (ARB_MODE == 1) ? ARB_RR : ARB_FIXED;

  logic [NUM_MASTERS-1:0] w_eligible;
  logic                   w_granted;
  logic [c_id_w-1:0]      w_grant;
  logic                   w_accept;
  logic                   w_push;
  logic                   w_pop;
  logic [c_id_w-1:0]      w_head;
  logic [c_cnt_w-1:0]     w_count;
  logic                   w_full;
  logic                   w_empty;
  logic                   r_lock;
  logic [c_id_w-1:0]      r_locked_id;
  logic [c_id_w-1:0]      r_rr_ptr;
  logic                   r_err;

  // Reads are held off while the ID FIFO is full, using the registered count.
  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_elig
    assign w_eligible[i] = (m_read[i] | m_write[i]) & ~(m_read[i] & w_full);
  end

  always_comb begin
    int j;
    w_granted = 1'b0;
    w_grant   = '0;
    j         = 0;
    if (r_lock) begin
      w_granted = 1'b1;
      w_grant   = r_locked_id;
    end else if (c_mode == ARB_FIXED) begin
      for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
        if (w_eligible[k]) begin
          w_granted = 1'b1;
          w_grant   = c_id_w'(k);
        end
      end
    end else begin
      // Scan downward so the candidate closest to rr_ptr is written last.
      for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
        j = int'(r_rr_ptr) + k;
        if (j >= NUM_MASTERS) begin
          j = j - NUM_MASTERS;
        end
        if (w_eligible[j]) begin
          w_granted = 1'b1;
          w_grant   = c_id_w'(j);
        end
      end
    end
  end

  assign s_address    = m_address[w_grant];
  assign s_writedata  = m_writedata[w_grant];
  assign s_byteenable = m_byteenable[w_grant];
  assign s_read       = w_granted & m_read[w_grant];
  assign s_write      = w_granted & m_write[w_grant];

  assign w_accept = w_granted && !s_waitrequest;
  assign w_push   = w_accept && m_read[w_grant];
  assign w_pop    = s_readdatavalid && !w_empty;

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_mst
    assign m_waitrequest[i]   = !(w_granted && (w_grant == c_id_w'(i))) || s_waitrequest;
    assign m_readdatavalid[i] = w_pop && (w_head == c_id_w'(i));
  end

  assign m_readdata    = s_readdata;
  assign err_unexp_rdv = r_err;

  avl_arb_id_fifo #(
    .DEPTH (MAX_PENDING),
    .WIDTH (c_id_w)
  ) u_id_fifo (
    .clk     (clk),
    .rest    (rest),
    .push    (w_push),
    .push_id (w_grant),
    .pop     (w_pop),
    .head    (w_head),
    .count   (w_count),
    .full    (w_full),
    .empty   (w_empty)
  );

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      r_lock      <= 1'b0;
      r_locked_id <= '0;
      r_rr_ptr    <= '0;
      r_err       <= 1'b0;
    end else begin
      // A stalled grant is pinned until the slave takes it.
      r_lock <= w_granted && s_waitrequest;
      if (w_granted && s_waitrequest) begin
        r_locked_id <= w_grant;
      end
      if (w_accept && (c_mode == ARB_RR)) begin
        r_rr_ptr <= (w_grant == c_id_w'(NUM_MASTERS - 1)) ? '0 : w_grant + 1'b1;
      end
      if (s_readdatavalid && (w_count == '0)) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_avl_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_avl_bus_arbiter                                                         |
// | Fixed-priority and round-robin arbiters under random master/slave traffic. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_avl_bus_arbiter;

  localparam int N  = 3;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  typedef struct {
    int            id;
    bit            rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
  } req_t;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
  } rdret_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit done [2];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Slave memory contents: derived from the address so expectations need no DUT readback.
  function automatic logic [DW-1:0] rdfun(input logic [AW-1:0] a);
    return {~a, a} ^ 32'h3C3C_0000;
  endfunction

  for (genvar c = 0; c < 2; c++) begin : g_env
    localparam int MP = (c == 0) ? 4 : 2;

    logic                   rest;
    logic [N-1:0][AW-1:0]   m_address;
    logic [N-1:0]           m_read;
    logic [N-1:0]           m_write;
    logic [N-1:0][DW-1:0]   m_writedata;
    logic [N-1:0][BW-1:0]   m_byteenable;
    logic [N-1:0]           m_waitrequest;
    logic [DW-1:0]          m_readdata;
    logic [N-1:0]           m_readdatavalid;
    logic [AW-1:0]          s_address;
    logic                   s_read;
    logic                   s_write;
    logic [DW-1:0]          s_writedata;
    logic [BW-1:0]          s_byteenable;
    logic                   s_waitrequest;
    logic [DW-1:0]          s_readdata;
    logic                   s_readdatavalid;
    logic                   err_unexp_rdv;

    avl_bus_arbiter #(
      .NUM_MASTERS (N),
      .ADDR_W      (AW),
      .DATA_W      (DW),
      .MAX_PENDING (MP),
      .ARB_MODE    (c)
    ) dut (
      .clk             (clk),
      .rest            (rest),
      .m_address       (m_address),
      .m_read          (m_read),
      .m_write         (m_write),
      .m_writedata     (m_writedata),
      .m_byteenable    (m_byteenable),
      .m_waitrequest   (m_waitrequest),
      .m_readdata      (m_readdata),
      .m_readdatavalid (m_readdatavalid),
      .s_address       (s_address),
      .s_read          (s_read),
      .s_write         (s_write),
      .s_writedata     (s_writedata),
      .s_byteenable    (s_byteenable),
      .s_waitrequest   (s_waitrequest),
      .s_readdata      (s_readdata),
      .s_readdatavalid (s_readdatavalid),
      .err_unexp_rdv   (err_unexp_rdv)
    );

    req_t          exp_req [$];
    rdret_t        exp_rd  [$];
    logic [DW-1:0] slv_q   [$];
    int            rr;
    int            lk_id;
    int            pend;
    int            rel;
    bit            lk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      check($sformatf("cfg%0d %s", c, nm), act, exp);
    endtask

    task automatic clear_model();
      rr    = 0;
      lk    = 1'b0;
      lk_id = 0;
      pend  = 0;
      rel   = -1;
      exp_req.delete();
      exp_rd.delete();
      slv_q.delete();
      m_read          = '0;
      m_write         = '0;
      s_waitrequest   = 1'b0;
      s_readdatavalid = 1'b0;
    endtask

    // One bus cycle: drive, predict the grant from the arbitration rules, check, advance model.
    task automatic one_cycle(input int req_pct, input int ret_pct);
      bit           gv;
      bit           acc;
      bit           rd;
      int           g;
      int           j;
      logic [N-1:0] elig;
      logic [N-1:0] exp_wait;
      @(posedge clk);
      #1;
      if (rel >= 0) begin
        m_read[rel]  = 1'b0;
        m_write[rel] = 1'b0;
        rel          = -1;
      end
      for (int i = 0; i < N; i++) begin
        if (!(m_read[i] || m_write[i]) && ($urandom_range(99) < req_pct)) begin
          rd              = ($urandom_range(1) == 1);
          m_read[i]       = rd;
          m_write[i]      = !rd;
          m_address[i]    = AW'($urandom);
          m_writedata[i]  = $urandom;
          m_byteenable[i] = BW'($urandom);
        end
      end
      s_waitrequest = ($urandom_range(99) < 25);
      if ((slv_q.size() > 0) && ($urandom_range(99) < ret_pct)) begin
        s_readdatavalid = 1'b1;
        s_readdata      = slv_q[0];
      end else begin
        s_readdatavalid = 1'b0;
        s_readdata      = $urandom;
      end
      gv = 1'b0;
      g  = 0;
      for (int i = 0; i < N; i++) begin
        elig[i] = (m_read[i] || m_write[i]) && !(m_read[i] && (pend == MP));
      end
      if (lk) begin
        gv = 1'b1;
        g  = lk_id;
      end else begin
        for (int k = 0; k < N; k++) begin
          j = (c == 1) ? (rr + k) % N : k;
          if (!gv && elig[j]) begin
            gv = 1'b1;
            g  = j;
          end
        end
      end
      acc      = gv && !s_waitrequest;
      exp_wait = '1;
      if (acc) begin
        exp_wait[g] = 1'b0;
        exp_req.push_back('{g, m_read[g], m_address[g], m_writedata[g], m_byteenable[g]});
        if (m_read[g]) begin
          exp_rd.push_back('{g, rdfun(m_address[g])});
        end
      end
      @(negedge clk);
      chk("waitrequest", 64'(m_waitrequest), 64'(exp_wait));
      chk("s_read", 64'(s_read), 64'(gv && m_read[g]));
      chk("s_write", 64'(s_write), 64'(gv && m_write[g]));
      if (gv) begin
        chk("s_address", 64'(s_address), 64'(m_address[g]));
      end
      pend = pend + ((acc && m_read[g]) ? 1 : 0) - ((s_readdatavalid && (pend > 0)) ? 1 : 0);
      lk   = gv && s_waitrequest;
      if (lk) begin
        lk_id = g;
      end
      if (acc) begin
        if (c == 1) begin
          rr = (g + 1) % N;
        end
        rel = g;
      end
    endtask

    task automatic drain();
      int t;
      t = 0;
      while ((((m_read | m_write) != '0) || (rel >= 0) || (slv_q.size() > 0)) && (t < 300)) begin
        one_cycle(0, 100);
        t++;
      end
      chk("drain finished", 64'(t < 300), 64'(1));
      chk("request queue empty", 64'(exp_req.size()), 64'(0));
      chk("readback queue empty", 64'(exp_rd.size()), 64'(0));
      chk("err clear", 64'(err_unexp_rdv), 64'(0));
    endtask

    // Scoreboard monitor: slave-side accepts and master-side read returns.
    initial begin
      req_t         e;
      rdret_t       r;
      logic [N-1:0] exp_v;
      forever begin
        @(negedge clk);
        if (rest) begin
          if ((s_read || s_write) && !s_waitrequest) begin
            chk("accept expected", 64'(exp_req.size() > 0), 64'(1));
            if (exp_req.size() > 0) begin
              e = exp_req.pop_front();
              chk("acc master addr", 64'(s_address), 64'(e.addr));
              chk("acc read", 64'(s_read), 64'(e.rd));
              chk("acc be", 64'(s_byteenable), 64'(e.be));
              if (!e.rd) begin
                chk("acc wdata", 64'(s_writedata), 64'(e.wdata));
              end
            end
            if (s_read) begin
              slv_q.push_back(rdfun(s_address));
            end
          end
          if (s_readdatavalid && (slv_q.size() > 0)) begin
            void'(slv_q.pop_front());
          end
          if (m_readdatavalid != '0) begin
            chk("readdatavalid expected", 64'(exp_rd.size() > 0), 64'(1));
            if (exp_rd.size() > 0) begin
              r           = exp_rd.pop_front();
              exp_v       = '0;
              exp_v[r.id] = 1'b1;
              chk("rdv master", 64'(m_readdatavalid), 64'(exp_v));
              chk("rdv data", 64'(m_readdata), 64'(r.data));
            end
          end
        end
      end
    end

    initial begin
      rest         = 1'b0;
      m_address    = '0;
      m_writedata  = '0;
      m_byteenable = '0;
      s_readdata   = '0;
      clear_model();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset waitrequest", 64'(m_waitrequest), 64'({N{1'b1}}));
      chk("reset s_read", 64'(s_read), 64'(0));
      chk("reset s_write", 64'(s_write), 64'(0));
      chk("reset rdv", 64'(m_readdatavalid), 64'(0));
      chk("reset err", 64'(err_unexp_rdv), 64'(0));
      @(posedge clk);
      #1 rest = 1'b1;

      // Slow returns first so the outstanding-read limit is reached often.
      for (int n = 0; n < 400; n++) begin
        one_cycle(70, (n < 200) ? 25 : 70);
      end
      drain();

      @(posedge clk);
      #1;
      s_readdatavalid = 1'b1;
      s_readdata      = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("unexpected rdv forwarded", 64'(m_readdatavalid), 64'(0));
      chk("err before edge", 64'(err_unexp_rdv), 64'(0));
      @(posedge clk);
      #1 s_readdatavalid = 1'b0;
      @(negedge clk);
      chk("err set", 64'(err_unexp_rdv), 64'(1));

      for (int n = 0; n < 30; n++) begin
        one_cycle(80, 20);
      end
      chk("err sticky", 64'(err_unexp_rdv), 64'(1));

      // Asynchronous reset in the middle of a cycle with reads in flight.
      #2 rest = 1'b0;
      clear_model();
      #1;
      chk("midreset err", 64'(err_unexp_rdv), 64'(0));
      chk("midreset rdv", 64'(m_readdatavalid), 64'(0));
      chk("midreset waitrequest", 64'(m_waitrequest), 64'({N{1'b1}}));
      chk("midreset s_read", 64'(s_read), 64'(0));
      repeat (2) @(posedge clk);
      #1 rest = 1'b1;

      for (int n = 0; n < 200; n++) begin
        one_cycle(60, 60);
      end
      drain();
      done[c] = 1'b1;
    end
  end

  initial begin
    for (int t = 0; t < 20000; t++) begin
      if (done[0] && done[1]) begin
        break;
      end
      @(posedge clk);
    end
    n_total++;
    if (done[0] && done[1]) begin
      n_pass++;
    end else begin
      $display("FAIL timeout: done=%0d%0d, expected 11", done[0], done[1]);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
